block_swap_sched: RTL
=====================

# block_swap_sched

Sequences SD-card block swaps for the SRAM block cache and shares the single swap datapath between two miss requesters (instruction-side and data-side address translators). It owns the slot table (resident SD block address, valid and dirty bits per SRAM slot), picks a victim slot, drives one swap request to the block swap controller, and reports the resident slot back to the requester. It sits in the user domain between the translators and the block swap controller.

## Interface
- NumSlots, default NUM_SRAM_ADDRESSES: number of SRAM block slots, a power of two ≥ 2.
- NumReq, default 2: number of miss requesters, fixed at 2 in this revision.
- SlotW, default $clog2(NumSlots): slot index width. Derived; not overridden.
- clk_i  in  1  clock. Single clock domain.
- rst_ni  in  1  reset. Asynchronous, active-low.
- miss_req_i  in  NumReq  level request. Held high until the matching miss_done_o pulse.
- miss_addr_i  in  NumReq×21  SD block address for each requester. Stable while its request is high.
- miss_done_o  out  NumReq  one-cycle done pulse, per requester.
- miss_slot_o  out  SlotW  slot holding the requested block. Valid in the miss_done_o cycle.
- wr_hit_i  in  1  a write hit in a resident slot.
- wr_hit_slot_i  in  SlotW  slot index for wr_hit_i. Marks that slot dirty.
- swap_req_o  out  1  one-cycle swap start pulse.
- old_addr_idx_o  out  SlotW  victim slot index.
- old_addr_o  out  21  SD address of the victim block, used for write-back.
- new_addr_o  out  21  SD address of the block to load.
- block_only_load_on_o  out  1  1 = load only, no write-back.
- swap_done_i  in  1  one-cycle swap completion pulse.

## Operation
- The FSM has five states: IDLE, ARB, LOOKUP, ISSUE, WAIT_DONE. The reset state is IDLE.
- Slot table: one entry per slot holding valid, dirty and tag[20:0]. Reset clears every entry to 0.
- IDLE → ARB when any miss_req_i bit is high.
- ARB picks the winner by round-robin. A last-grant pointer resets to requester 1, so requester 0 wins the first tie. The winner's index and address are latched. ARB → LOOKUP.
- LOOKUP compares the latched address against every valid tag. There are two outcomes:
  - Hit: pulse miss_done_o[winner] with miss_slot_o = the matching slot, then → IDLE with no swap. This covers a block that was already loaded for the other requester.
  - Miss: choose the victim as the lowest-index invalid slot. If no slot is invalid, the victim is the round-robin victim pointer (reset value 0). → ISSUE.
- ISSUE drives the following and then → WAIT_DONE:
  - swap_req_o = 1 for exactly one cycle.
  - old_addr_idx_o = victim.
  - old_addr_o = victim tag.
  - new_addr_o = latched address.
  - block_only_load_on_o = !(valid & dirty) of the victim.
  - In the same cycle the victim entry is set to valid = 0.
- WAIT_DONE holds old_addr_idx_o, old_addr_o, new_addr_o and block_only_load_on_o stable until swap_done_i arrives. On swap_done_i:
  - The victim entry becomes valid = 1, dirty = 0, tag = new address.
  - The victim pointer advances by one, modulo NumSlots, only when the victim came from the pointer.
  - miss_done_o[winner] pulses with miss_slot_o = victim, then → IDLE.
- wr_hit_i sets dirty on wr_hit_slot_i only if that slot is valid. A write hit on an invalid slot, including the slot currently being swapped, is dropped.
- swap_done_i outside WAIT_DONE is ignored.
- A miss_req_i that drops before done is a protocol violation. The FSM still completes the operation.
- Reset in any state returns to IDLE and clears the slot table and both pointers. The downstream swap is not cancelled; its late swap_done_i is ignored.

## Timing
- Every output resets to 0.
- Hit latency: request high in cycle 0 (IDLE), ARB in cycle 1, LOOKUP with the miss_done_o pulse in cycle 2.
- Miss latency: swap_req_o in cycle 3. miss_done_o is registered and pulses 1 cycle after swap_done_i.
- swap_req_o and swap_done_i are not back-to-back. IDLE and ARB separate consecutive swaps, giving at least 2 cycles of gap.
- The loser of an arbitration keeps its request high and is served next. Its LOOKUP re-checks the table, so a block just loaded for the other requester is returned as a hit.
- A wr_hit_i coinciding with swap_done_i on the same slot is dropped: the entry is marked clean.

## Structure
- block_swap_sched_pkg, or extend user_pkg, holds:
  - the state enum;
  - the slot entry struct {valid, dirty, tag};
  - the constant BLOCK_ADDR_W = 21.
- NumSlots is taken from NUM_SRAM_ADDRESSES in croc_pkg.
- One sub-module: rr_arb2, a 2-way round-robin arbiter with a pointer register. Alternatively use common_cells rr_arb_tree.
- Registers use the `FF macros.

## Test plan
- Cold miss: req0 with addr 0x00010 → swap_req_o with idx 0, load-only = 1, new_addr_o = 0x00010. swap_done_i → done0 with slot 0.
- Re-hit: req1 with addr 0x00010 after the cold miss → done1 in cycle 2, slot 0, no swap_req_o.
- Dirty eviction: fill all NumSlots slots, wr_hit_i on slot 0, then miss on 0x1FFFF → victim 0, old_addr_o = slot 0 tag, load-only = 0. A later eviction of clean slot 1 gives load-only = 1.
- Arbitration: req0 and req1 rise together with distinct addresses → req0 is served first, then req1. Next simultaneous pair → req1 first.
- Collision: wr_hit_i on the victim slot during WAIT_DONE, then a swap_done_i stray in IDLE → dirty stays 0 and no state change.
- Reset mid-WAIT_DONE: rst_ni low for 1 cycle → all outputs 0, table empty, next miss uses slot 0 with load-only = 1.

Source files
------------

// File: rtl/block_swap_sched_pkg.sv
// Shared types for the SRAM block-cache swap scheduler.
// Slot entry layout, FSM states and block address width.
package block_swap_sched_pkg;

  localparam int unsigned NUM_SRAM_ADDRESSES = 4;
  localparam int unsigned BLOCK_ADDR_W = 21;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LOOKUP,
    ISSUE,
    WAIT_DONE
  } state_e;

  typedef struct packed {
    logic                    valid;
    logic                    dirty;
    logic [BLOCK_ADDR_W-1:0] tag;
  } slot_t;

endpackage

// File: rtl/block_swap_sched_rr_arb2.sv
// Two-way round-robin arbiter with a last-grant pointer.
// The pointer only moves on a contested grant.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       gnt_o,
  output logic       vld_o
);

  logic last_q;

  always_comb begin
    vld_o = |req_i;
    gnt_o = 1'b0;
    unique case (req_i)
      2'b11:   gnt_o = ~last_q;
      2'b10:   gnt_o = 1'b1;
      default: gnt_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else if (en_i && (req_i == 2'b11)) begin
      last_q <= gnt_o;
    end
  end

endmodule

// File: rtl/block_swap_sched.sv
// Miss scheduler for the SRAM block cache: slot table, victim choice
// and a single shared swap request towards the block swap controller.
module block_swap_sched
  import block_swap_sched_pkg::*;
#(
  parameter int unsigned NumSlots = NUM_SRAM_ADDRESSES,
  parameter int unsigned NumReq   = 2,
  parameter int unsigned SlotW    = $clog2(NumSlots)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   miss_req_i,
  input  logic [NumReq-1:0][BLOCK_ADDR_W-1:0] miss_addr_i,
  output logic [NumReq-1:0]                   miss_done_o,
  output logic [SlotW-1:0]                    miss_slot_o,
  input  logic                                wr_hit_i,
  input  logic [SlotW-1:0]                    wr_hit_slot_i,
  output logic                                swap_req_o,
  output logic [SlotW-1:0]                    old_addr_idx_o,
  output logic [BLOCK_ADDR_W-1:0]             old_addr_o,
  output logic [BLOCK_ADDR_W-1:0]             new_addr_o,
  output logic                                block_only_load_on_o,
  input  logic                                swap_done_i
);

  state_e                  state_q;
  slot_t                   tbl_q [NumSlots];
  logic                    win_q;
  logic [BLOCK_ADDR_W-1:0] addr_q;
  logic                    hit_q;
  logic                    from_ptr_q;
  logic [SlotW-1:0]        vptr_q;
  logic [NumReq-1:0]       done_q;
  logic [SlotW-1:0]        slot_q;
  logic                    swap_q;
  logic [SlotW-1:0]        idx_q;
  logic [BLOCK_ADDR_W-1:0] old_q;
  logic [BLOCK_ADDR_W-1:0] new_q;
  logic                    lo_q;

  logic                    gnt;
  logic                    gnt_vld;
  logic [NumReq-1:0]       req_eff;
  logic                    hit_c;
  logic [SlotW-1:0]        hit_slot;
  logic                    inv_found;
  logic [SlotW-1:0]        inv_idx;
  logic [SlotW-1:0]        victim;
  logic                    wr_vic;

  rr_arb2 u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (miss_req_i),
    .en_i   (state_q == ARB),
    .gnt_o  (gnt),
    .vld_o  (gnt_vld)
  );

  // a requester still high during its own done pulse must not re-arm
  assign req_eff = miss_req_i & ~done_q;

  always_comb begin
    hit_c     = 1'b0;
    hit_slot  = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (!hit_c && tbl_q[i].valid &&
          tbl_q[i].tag == miss_addr_i[gnt]) begin
        hit_c    = 1'b1;
        hit_slot = SlotW'(i);
      end
    end
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!tbl_q[i].valid) begin
        inv_found = 1'b1;
        inv_idx   = SlotW'(i);
      end
    end
    victim = inv_found ? inv_idx : vptr_q;
    wr_vic = wr_hit_i && (wr_hit_slot_i == victim);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      for (int i = 0; i < NumSlots; i++) tbl_q[i] <= '0;
      win_q      <= 1'b0;
      addr_q     <= '0;
      hit_q      <= 1'b0;
      from_ptr_q <= 1'b0;
      vptr_q     <= '0;
      done_q     <= '0;
      slot_q     <= '0;
      swap_q     <= 1'b0;
      idx_q      <= '0;
      old_q      <= '0;
      new_q      <= '0;
      lo_q       <= 1'b0;
    end else begin
      done_q <= '0;
      swap_q <= 1'b0;
      if (wr_hit_i && tbl_q[wr_hit_slot_i].valid) begin
        tbl_q[wr_hit_slot_i].dirty <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (|req_eff) state_q <= ARB;
        end
        ARB: begin
          if (!gnt_vld) begin
            state_q <= IDLE;
          end else begin
            win_q   <= gnt;
            addr_q  <= miss_addr_i[gnt];
            hit_q   <= hit_c;
            state_q <= LOOKUP;
            if (hit_c) begin
              done_q[gnt] <= 1'b1;
              slot_q      <= hit_slot;
            end
          end
        end
        LOOKUP: begin
          if (hit_q) begin
            state_q <= IDLE;
          end else begin
            swap_q     <= 1'b1;
            idx_q      <= victim;
            old_q      <= tbl_q[victim].tag;
            new_q      <= addr_q;
            // a write landing this cycle must still force write-back
            lo_q       <= !(tbl_q[victim].valid &&
                            (tbl_q[victim].dirty || wr_vic));
            from_ptr_q <= !inv_found;
            tbl_q[victim].valid <= 1'b0;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (swap_done_i) begin
            tbl_q[idx_q] <= '{valid: 1'b1, dirty: 1'b0, tag: new_q};
            if (from_ptr_q) vptr_q <= vptr_q + SlotW'(1);
            done_q[win_q] <= 1'b1;
            slot_q        <= idx_q;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miss_done_o          = done_q;
  assign miss_slot_o          = slot_q;
  assign swap_req_o           = swap_q;
  assign old_addr_idx_o       = idx_q;
  assign old_addr_o           = old_q;
  assign new_addr_o           = new_q;
  assign block_only_load_on_o = lo_q;

endmodule
